// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment digit driver.
// The optional leading-zero blanking feature is enabled by defining SSEG_LZB_EN.
package sseg_pkg;

    // Cathode vector {g,f,e,d,c,b,a}, active-low.
    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low one-hot anode codes, digit 0 is the rightmost.
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    // Hex glyph table, index 0 is the rightmost element of the concatenation.
    localparam seg_t [15:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble-to-cathode decoder driven from the shared glyph table.
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/sseg_digit_driver.sv
// Cathode and anode driver for a 4-digit multiplexed display.
// Follows the anode rotator's select, buffers the display value until the
// frame wraps to digit 0, and blanks the anodes for a guard interval after
// every select change. Leading-zero blanking is enabled by SSEG_LZB_EN.
//
// load is a single-cycle strobe with no back-pressure: whenever it is high at
// a clock edge data_in/dp_in are taken, replacing any value still pending.
module sseg_digit_driver
    import sseg_pkg::*;
#(
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_sel,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        pending,
    output logic [3:0]  an_out,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        sel_err
);

    localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

    logic [3:0]    an_q;
    logic [CW-1:0] guard_cnt;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;

    logic          change;
    logic          commit;
    logic          dig_valid;
    logic [1:0]    dig_idx;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;
    logic [3:0]    lzb_blank;

    assign change = (an_sel != an_q);
    assign commit = change && (an_sel == AN_DIG0);

    // Track the select and (re)arm the anode guard counter on every change.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q      <= AN_OFF;
            guard_cnt <= '0;
        end else begin
            an_q <= an_sel;
            if (change) begin
                guard_cnt <= CW'(BLANK_CYCLES);
            end else if (guard_cnt != '0) begin
                guard_cnt <= guard_cnt - CW'(1);
            end
        end
    end

    // Hold a loaded value until the frame boundary, then move it to the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
        end else if (commit) begin
            if (load) begin
                disp_val <= data_in;
                disp_dp  <= dp_in;
            end else if (pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= data_in;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
        end
    end

    // Map the registered select onto a digit index; anything else is invalid.
    always_comb begin
        dig_valid = 1'b1;
        dig_idx   = 2'd0;
        case (an_q)
            AN_DIG0: dig_idx = 2'd0;
            AN_DIG1: dig_idx = 2'd1;
            AN_DIG2: dig_idx = 2'd2;
            AN_DIG3: dig_idx = 2'd3;
            default: dig_valid = 1'b0;
        endcase
    end

    assign cur_nibble = disp_val[{dig_idx, 2'b00} +: 4];

    sseg_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SSEG_LZB_EN
    // Blank leading zeros from the left; a lit decimal point ends the run.
    always_comb begin
        lzb_blank    = 4'b0000;
        lzb_blank[3] = (disp_val[15:12] == 4'h0) && !disp_dp[3];
        lzb_blank[2] = lzb_blank[3] && (disp_val[11:8] == 4'h0) && !disp_dp[2];
        lzb_blank[1] = lzb_blank[2] && (disp_val[7:4] == 4'h0) && !disp_dp[1];
    end
`else
    assign lzb_blank = 4'b0000;
`endif

    // Register the pin outputs so anodes and cathodes switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_out  <= AN_OFF;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
            sel_err <= 1'b0;
        end else begin
            an_out  <= (guard_cnt != '0) ? AN_OFF : an_q;
            seg     <= (dig_valid && !lzb_blank[dig_idx]) ? dec_seg : SEG_BLANK;
            dp      <= dig_valid ? ~disp_dp[dig_idx] : 1'b1;
            sel_err <= !dig_valid && (an_q != AN_OFF);
        end
    end

endmodule
